// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational reads, two synchronous writes.
// Port A has byte enables and wins per byte over port B on a collision.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [ADDR_W-1:0]   rs,
    input  logic [ADDR_W-1:0]   rt,
    output logic [DATA_W-1:0]   sourceReg,
    output logic [DATA_W-1:0]   secondaryReg,
    input  logic [ADDR_W-1:0]   rd,
    input  logic                writeSig,
    input  logic [DATA_W/8-1:0] writeByteEn,
    input  logic [DATA_W-1:0]   writeData,
    input  logic [ADDR_W-1:0]   rd2,
    input  logic                writeSig2,
    input  logic [DATA_W-1:0]   writeData2
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Per-register merged next value; addresses are compared against each
    // implemented index so out-of-range addresses never match anything.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
            if (ZERO_REG == 0 || r != 0) begin
                for (int b = 0; b < NB; b++) begin
                    if (writeSig && rd == ADDR_W'(r) && writeByteEn[b]) begin
                        regs_d[r][8*b +: 8] = writeData[8*b +: 8];
                    end else if (writeSig2 && rd2 == ADDR_W'(r)) begin
                        regs_d[r][8*b +: 8] = writeData2[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read muxes: bypass shows the pending value, suppressed during reset.
    always_comb begin
        sourceReg    = '0;
        secondaryReg = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (ZERO_REG == 0 || r != 0) begin
                if (rs == ADDR_W'(r)) begin
                    sourceReg = (BYPASS != 0 && Rst_n) ? regs_d[r] : regs_q[r];
                end
                if (rt == ADDR_W'(r)) begin
                    secondaryReg = (BYPASS != 0 && Rst_n) ? regs_d[r] : regs_q[r];
                end
            end
        end
    end

    // Synchronous clear overrides both write ports.
    always_ff @(posedge Clk) begin
        for (int r = 0; r < DEPTH; r++) begin
            if (!Rst_n) begin
                regs_q[r] <= '0;
            end else begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: u0 uses defaults (zero reg, bypass),
// u1 has DEPTH=16, ordinary reg 0 and no bypass; both share stimulus.
module tb_reg_file_mp;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [4:0]  rs, rt, rd, rd2;
    logic        writeSig, writeSig2;
    logic [3:0]  writeByteEn;
    logic [31:0] writeData, writeData2;
    logic [31:0] src0, sec0, src1, sec1;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    reg_file_mp u0 (
        .Clk(Clk), .Rst_n(Rst_n), .rs(rs), .rt(rt),
        .sourceReg(src0), .secondaryReg(sec0),
        .rd(rd), .writeSig(writeSig), .writeByteEn(writeByteEn),
        .writeData(writeData), .rd2(rd2), .writeSig2(writeSig2),
        .writeData2(writeData2)
    );

    reg_file_mp #(.DEPTH(16), .ZERO_REG(0), .BYPASS(0)) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .rs(rs), .rt(rt),
        .sourceReg(src1), .secondaryReg(sec1),
        .rd(rd), .writeSig(writeSig), .writeByteEn(writeByteEn),
        .writeData(writeData), .rd2(rd2), .writeSig2(writeSig2),
        .writeData2(writeData2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        writeSig  = 1'b0;
        writeSig2 = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0; rs = 5'd0; rt = 5'd0; rd = 5'd0; rd2 = 5'd0;
        writeSig = 1'b0; writeSig2 = 1'b0; writeByteEn = 4'h0;
        writeData = 32'h0; writeData2 = 32'h0;
        tick();
        rs = 5'd3; rt = 5'd12;
        #1;
        chk("rst0_u0_rs", src0, 32'h0);
        chk("rst0_u1_rt", sec1, 32'h0);

        // Preload 5 (port A) and 31 (port B)
        Rst_n = 1'b1;
        writeSig = 1'b1; rd = 5'd5; writeByteEn = 4'hF; writeData = 32'hDEADBEEF;
        writeSig2 = 1'b1; rd2 = 5'd31; writeData2 = 32'hDEADBEEF;
        tick(); idle();
        rs = 5'd5; rt = 5'd31;
        #1;
        chk("pre_u0_r5", src0, 32'hDEADBEEF);
        chk("pre_u0_r31", sec0, 32'hDEADBEEF);
        chk("pre_u1_r5", src1, 32'hDEADBEEF);
        chk("pre_u1_r31_oor", sec1, 32'h0);

        // Reset discards a concurrent write; bypass suppressed in reset
        Rst_n = 1'b0;
        writeSig = 1'b1; rd = 5'd8; writeByteEn = 4'hF; writeData = 32'd456;
        rs = 5'd8; rt = 5'd5;
        #1;
        chk("rst_nobyp_u0", src0, 32'h0);
        tick(); idle(); Rst_n = 1'b1;
        #1;
        chk("rst_u0_r8", src0, 32'h0);
        chk("rst_u0_r5", sec0, 32'h0);
        chk("rst_u1_r8", src1, 32'h0);
        chk("rst_u1_r5", sec1, 32'h0);
        rt = 5'd31;
        #1;
        chk("rst_u0_r31", sec0, 32'h0);

        // Basic write; same-cycle read
        writeSig = 1'b1; rd = 5'd8; writeByteEn = 4'hF; writeData = 32'd456;
        rs = 5'd8;
        #1;
        chk("wr_u1_same_old", src1, 32'h0);
        chk("wr_u0_same_byp", src0, 32'd456);
        tick(); idle();
        #1;
        chk("wr_u1_after", src1, 32'd456);
        chk("wr_u0_after", src0, 32'd456);

        // Zero register on both ports
        writeSig = 1'b1; rd = 5'd0; writeData = 32'd88888;
        writeSig2 = 1'b1; rd2 = 5'd0; writeData2 = 32'd88888;
        rs = 5'd0; rt = 5'd0;
        #1;
        chk("z_u0_rs_pre", src0, 32'h0);
        chk("z_u0_rt_pre", sec0, 32'h0);
        chk("z_u1_rs_pre", src1, 32'h0);
        tick(); idle();
        #1;
        chk("z_u0_rs_post", src0, 32'h0);
        chk("z_u0_rt_post", sec0, 32'h0);
        chk("z_u1_rs_post", src1, 32'd88888);

        // Byte enables with collision on reg 7
        writeSig2 = 1'b1; rd2 = 5'd7; writeData2 = 32'h11223344;
        tick(); idle();
        writeSig = 1'b1; rd = 5'd7; writeByteEn = 4'h5; writeData = 32'hAABBCCDD;
        writeSig2 = 1'b1; rd2 = 5'd7; writeData2 = 32'h55667788;
        rs = 5'd7;
        #1;
        chk("col_u0_byp", src0, 32'h55BB77DD);
        chk("col_u1_old", src1, 32'h11223344);
        tick(); idle();
        #1;
        chk("col_u0_post", src0, 32'h55BB77DD);
        chk("col_u1_post", src1, 32'h55BB77DD);

        // Partial bypass merge on reg 21
        writeSig = 1'b1; rd = 5'd21; writeByteEn = 4'hF; writeData = 32'h11223344;
        tick(); idle();
        writeSig = 1'b1; rd = 5'd21; writeByteEn = 4'h3; writeData = 32'h0000BEEF;
        rs = 5'd21; rt = 5'd21;
        #1;
        chk("byp_u0_rs", src0, 32'h1122BEEF);
        chk("byp_u0_rt", sec0, 32'h1122BEEF);
        chk("byp_u1_oor", src1, 32'h0);
        tick(); idle();
        #1;
        chk("byp_u0_post", src0, 32'h1122BEEF);
        chk("byp_u1_post", sec1, 32'h0);

        // Out of range: 25 must not alias onto 9 in u1
        writeSig = 1'b1; rd = 5'd25; writeByteEn = 4'hF; writeData = 32'h1234;
        writeSig2 = 1'b1; rd2 = 5'd9; writeData2 = 32'h9999;
        tick(); idle();
        rs = 5'd25; rt = 5'd9;
        #1;
        chk("oor_u1_r25", src1, 32'h0);
        chk("oor_u1_r9", sec1, 32'h9999);
        chk("oor_u0_r25", src0, 32'h1234);
        chk("oor_u0_r9", sec0, 32'h9999);

        // Port A with no byte enables lets port B write
        writeSig = 1'b1; rd = 5'd9; writeByteEn = 4'h0; writeData = 32'hFFFFFFFF;
        writeSig2 = 1'b1; rd2 = 5'd9; writeData2 = 32'hABCD;
        tick(); idle();
        rs = 5'd9;
        #1;
        chk("be0_u0", src0, 32'hABCD);
        chk("be0_u1", src1, 32'hABCD);

        // Unknown addresses with enables low leave state intact
        rd = 5'bx; rd2 = 5'bx; writeData = 32'hx; writeData2 = 32'hx;
        writeByteEn = 4'hx;
        tick();
        rt = 5'd8;
        #1;
        chk("x_u0_r9", src0, 32'hABCD);
        chk("x_u1_r9", src1, 32'hABCD);
        chk("x_u0_r8", sec0, 32'd456);
        chk("x_u1_r8", sec1, 32'd456);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
